if_id_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the IF/ID register and PC: load-use stall, taken-branch flush,

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/sat_counter.sv | 22 ++
 rtl/if_id_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_if_id_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the IF/ID pipeline sequencer.
//  REG_W      : register-index width
//  ST_*       : state encodings for the sequencer FSM
//  NOP_INSTR  : instruction word loaded on flush/bubble
package pipe_ctrl_pkg;

    localparam int unsigned REG_W   = 4;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_RUN      = 2'd0;
    localparam logic [STATE_W-1:0] ST_FLUSH    = 2'd1;
    localparam logic [STATE_W-1:0] ST_MEM_WAIT = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [STATE_W-1:0] {
        RUN      = ST_RUN,
        FLUSH    = ST_FLUSH,
        MEM_WAIT = ST_MEM_WAIT
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
//  clk, rst_n : clock, async active-low reset (clears count)
//  inc        : increment request
//  count      : current value
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID and PC sequencer: load-use stall, taken-branch flush, data-memory freeze.
//  Inputs : ID source regs/uses, EX load/dest, br_taken, mem_req/mem_ready
//  Outputs: pc_we, pc_sel_target, if_id_we, if_id_flush, id_ex_bubble,
//           pipe_freeze (combinational); err_timeout, stall_cnt, flush_cnt (registered)
module if_id_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned BR_PENALTY  = 1,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rp,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_uses_rp,
    input  logic             id_uses_rs,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rg,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             pc_sel_target,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned PEN_W  = 3;
    localparam int unsigned WAIT_W = 16;

    state_t            state, state_nxt;
    logic [PEN_W-1:0]  pen_cnt, pen_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              from_flush, from_flush_nxt;
    logic              err_nxt;
    logic              lu, mw, freeze, run_rules;
    logic              stall_inc, flush_inc;

    // Hazard terms; register 0 is not special.
    assign lu = ex_valid & ex_is_load & id_valid &
                ((id_uses_rp & (id_rp == ex_rg)) | (id_uses_rs & (id_rs == ex_rg)));
    assign mw = mem_req & ~mem_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pen_cnt     <= '0;
            wait_cnt    <= '0;
            from_flush  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            pen_cnt     <= pen_nxt;
            wait_cnt    <= wait_nxt;
            from_flush  <= from_flush_nxt;
            err_timeout <= err_nxt;
        end
    end

    // Next state and zero-latency control outputs
    always_comb begin
        state_nxt      = state;
        pen_nxt        = pen_cnt;
        wait_nxt       = wait_cnt;
        from_flush_nxt = from_flush;
        err_nxt        = err_timeout;
        pc_we          = 1'b1;
        pc_sel_target  = 1'b0;
        if_id_we       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        pipe_freeze    = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        freeze         = 1'b0;
        run_rules      = 1'b0;

        case (state)
            RUN: begin
                if (mw) begin
                    freeze         = 1'b1;
                    state_nxt      = MEM_WAIT;
                    wait_nxt       = WAIT_W'(1);
                    from_flush_nxt = 1'b0;
                end else begin
                    run_rules = 1'b1;
                end
            end
            FLUSH: begin
                if (mw) begin
                    // Penalty count is held across the freeze.
                    freeze         = 1'b1;
                    state_nxt      = MEM_WAIT;
                    wait_nxt       = WAIT_W'(1);
                    from_flush_nxt = 1'b1;
                end else begin
                    if_id_we     = 1'b0;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    pen_nxt      = pen_cnt - PEN_W'(1);
                    if (pen_cnt <= PEN_W'(1)) begin
                        state_nxt = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                if (!mw) begin
                    // Release cycle: a branch held in EX is redirected now.
                    if (from_flush) begin
                        state_nxt = FLUSH;
                    end else begin
                        state_nxt = RUN;
                        run_rules = 1'b1;
                    end
                end else begin
                    freeze   = 1'b1;
                    wait_nxt = wait_cnt + WAIT_W'(1);
                    if (wait_cnt >= WAIT_W'(MEM_TIMEOUT)) begin
                        err_nxt   = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (run_rules) begin
            if (br_taken) begin
                pc_sel_target = 1'b1;
                if_id_we      = 1'b0;
                if_id_flush   = 1'b1;
                id_ex_bubble  = 1'b1;
                flush_inc     = 1'b1;
                if (BR_PENALTY > 0) begin
                    state_nxt = FLUSH;
                    pen_nxt   = PEN_W'(BR_PENALTY);
                end else begin
                    state_nxt = RUN;
                end
            end else if (lu) begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_bubble = 1'b1;
                stall_inc    = 1'b1;
            end
        end

        if (freeze) begin
            pipe_freeze = 1'b1;
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            stall_inc   = 1'b1;
        end

        // Reset holds the front end with NOPs in IF/ID and ID/EX.
        if (!rst_n) begin
            pc_we         = 1'b0;
            pc_sel_target = 1'b0;
            if_id_we      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            pipe_freeze   = 1'b0;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Bench for if_id_hazard_ctrl: directed scenarios followed by random traffic,
// every cycle checked against a behavioural model of the sequencing rules.
module tb_if_id_hazard_ctrl;

    localparam int unsigned BR_PENALTY  = 1;
    localparam int unsigned MEM_TIMEOUT = 6;
    localparam int unsigned CNT_W       = 4;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             id_valid, id_uses_rp, id_uses_rs;
    logic [3:0]       id_rp, id_rs, ex_rg;
    logic             ex_valid, ex_is_load, br_taken, mem_req, mem_ready;
    logic             pc_we, pc_sel_target, if_id_we, if_id_flush;
    logic             id_ex_bubble, pipe_freeze, err_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Model: waiting on memory, remaining flush cycles, wait length, sticky error, counts
    bit m_wait, n_wait;
    int m_pen, n_pen;
    int m_waited, n_waited;
    bit m_err, n_err;
    int m_stall, n_stall;
    int m_flush, n_flush;
    logic e_pc_we, e_sel, e_ifid_we, e_flush, e_bubble, e_freeze;

    if_id_hazard_ctrl #(
        .BR_PENALTY  (BR_PENALTY),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rp         (id_rp),
        .id_rs         (id_rs),
        .id_uses_rp    (id_uses_rp),
        .id_uses_rs    (id_uses_rs),
        .ex_valid      (ex_valid),
        .ex_is_load    (ex_is_load),
        .ex_rg         (ex_rg),
        .br_taken      (br_taken),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_we         (pc_we),
        .pc_sel_target (pc_sel_target),
        .if_id_we      (if_id_we),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .pipe_freeze   (pipe_freeze),
        .err_timeout   (err_timeout),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? v : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outputs and next model state for the current inputs.
    task automatic model_eval();
        bit lu, mw;
        if (!rst_n) begin
            m_wait = 0; m_pen = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end
        n_wait = m_wait; n_pen = m_pen; n_waited = m_waited;
        n_err = m_err; n_stall = m_stall; n_flush = m_flush;
        e_pc_we = 1; e_sel = 0; e_ifid_we = 1; e_flush = 0; e_bubble = 0; e_freeze = 0;
        lu = ex_valid && ex_is_load && id_valid &&
             ((id_uses_rp && id_rp == ex_rg) || (id_uses_rs && id_rs == ex_rg));
        mw = mem_req && !mem_ready;
        if (!rst_n) begin
            e_pc_we = 0; e_ifid_we = 0; e_flush = 1; e_bubble = 1;
        end else if (mw) begin
            e_freeze = 1; e_pc_we = 0; e_ifid_we = 0;
            n_stall = sat_inc(m_stall);
            if (!m_wait) begin
                n_wait = 1; n_waited = 1;
            end else if (m_waited >= MEM_TIMEOUT) begin
                n_err = 1; n_wait = 0; n_pen = 0;
            end else begin
                n_waited = m_waited + 1;
            end
        end else if (m_wait && m_pen > 0) begin
            n_wait = 0;
        end else if (m_pen > 0) begin
            e_ifid_we = 0; e_flush = 1; e_bubble = 1;
            n_pen = m_pen - 1;
        end else begin
            n_wait = 0;
            if (br_taken) begin
                e_sel = 1; e_ifid_we = 0; e_flush = 1; e_bubble = 1;
                n_flush = sat_inc(m_flush);
                n_pen = BR_PENALTY;
            end else if (lu) begin
                e_pc_we = 0; e_ifid_we = 0; e_bubble = 1;
                n_stall = sat_inc(m_stall);
            end
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
        chk("pc_we", pc_we, e_pc_we);
        chk("pc_sel_target", pc_sel_target, e_sel);
        chk("if_id_we", if_id_we, e_ifid_we);
        chk("if_id_flush", if_id_flush, e_flush);
        chk("id_ex_bubble", id_ex_bubble, e_bubble);
        chk("pipe_freeze", pipe_freeze, e_freeze);
        chk("err_timeout", err_timeout, m_err);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic advance();
        @(posedge clk);
        m_wait = n_wait; m_pen = n_pen; m_waited = n_waited;
        m_err = n_err; m_stall = n_stall; m_flush = n_flush;
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rp = 0; id_rs = 0; id_uses_rp = 0; id_uses_rs = 0;
        ex_valid = 0; ex_is_load = 0; ex_rg = 0;
        br_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        settle();
        chk("rst_pc_we", pc_we, 0);
        chk("rst_flush", if_id_flush, 1);
        chk("rst_bubble", id_ex_bubble, 1);
        advance();
        do_reset();

        // Load-use on Rp: one stall cycle
        ex_valid = 1; ex_is_load = 1; ex_rg = 3; id_valid = 1; id_rp = 3; id_uses_rp = 1;
        settle();
        chk("t1_pc_we", pc_we, 0);
        chk("t1_if_id_we", if_id_we, 0);
        chk("t1_bubble", id_ex_bubble, 1);
        advance();
        chk("t1_stall_cnt", stall_cnt, 1);
        ex_valid = 0;
        step();

        // Register match without use: no stall; R0 match stalls
        ex_valid = 1; id_uses_rp = 0; id_uses_rs = 0;
        settle();
        chk("t2_no_stall", pc_we, 1);
        advance();
        ex_rg = 0; id_rs = 0; id_uses_rs = 1;
        settle();
        chk("t2_r0_stall", pc_we, 0);
        advance();
        idle_inputs();
        step();

        // Taken branch with one penalty cycle
        do_reset();
        br_taken = 1;
        settle();
        chk("t3_c0_sel", pc_sel_target, 1);
        chk("t3_c0_flush", if_id_flush, 1);
        advance();
        br_taken = 0;
        settle();
        chk("t3_c1_flush", if_id_flush, 1);
        chk("t3_c1_sel", pc_sel_target, 0);
        advance();
        settle();
        chk("t3_c2_flush", if_id_flush, 0);
        chk("t3_c2_pc_we", pc_we, 1);
        advance();
        chk("t3_flush_cnt", flush_cnt, 1);

        // Memory wait with branch held in EX
        do_reset();
        mem_req = 1; mem_ready = 0; br_taken = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t4_freeze", pipe_freeze, 1);
            advance();
        end
        mem_ready = 1;
        settle();
        chk("t4_release_freeze", pipe_freeze, 0);
        chk("t4_release_sel", pc_sel_target, 1);
        advance();
        chk("t4_stall_cnt", stall_cnt, 5);
        idle_inputs();
        step();
        step();

        // Memory timeout: entry cycle plus MEM_TIMEOUT wait cycles
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < int'(MEM_TIMEOUT); i++) step();
        chk("t5_err_early", err_timeout, 0);
        step();
        chk("t5_err_set", err_timeout, 1);
        mem_req = 0;
        step();
        step();
        chk("t5_err_sticky", err_timeout, 1);

        // Reset during memory wait
        do_reset();
        mem_req = 1; mem_ready = 0;
        step(); step(); step();
        rst_n = 0;
        settle();
        chk("t6_pc_we", pc_we, 0);
        chk("t6_flush", if_id_flush, 1);
        chk("t6_freeze", pipe_freeze, 0);
        chk("t6_stall_cnt", stall_cnt, 0);
        advance();
        rst_n = 1; mem_req = 0;
        step();

        // Random traffic, including counter saturation and occasional resets
        for (int i = 0; i < 600; i++) begin
            rst_n      = ($urandom_range(0, 149) != 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rp      = 4'($urandom_range(0, 3));
            id_rs      = 4'($urandom_range(0, 3));
            id_uses_rp = 1'($urandom);
            id_uses_rs = 1'($urandom);
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_is_load = 1'($urandom);
            ex_rg      = 4'($urandom_range(0, 3));
            br_taken   = ($urandom_range(0, 5) == 0);
            mem_req    = ($urandom_range(0, 3) == 0);
            mem_ready  = 1'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
